// File: rtl/flag_ctrl_pkg.sv
// Shared encodings for the flag controller: ops, branch conditions, FSM states, flag bit indices.
// Used by flag_ctrl and flag_cond_eval; the optional shadow is controlled by FLAG_SHADOW_EN in flag_ctrl.
package flag_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_CLR     = 3'd1,
        OP_TST     = 3'd2,
        OP_SAVE    = 3'd3,
        OP_RESTORE = 3'd4
    } op_e;

    typedef enum logic [2:0] {
        CC_ALWAYS = 3'd0,
        CC_C      = 3'd1,
        CC_NC     = 3'd2,
        CC_Z      = 3'd3,
        CC_NZ     = 3'd4,
        CC_B      = 3'd5,
        CC_NB     = 3'd6,
        CC_NEVER  = 3'd7
    } cond_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EVAL = 1'b1
    } state_e;

    localparam int FLAG_C = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_B = 0;

endpackage

// File: rtl/flag_ctrl_cond_eval.sv
// Combinational branch-condition decoder: maps a condition code and the {C,Z,B} flags to take/not-take.
module flag_cond_eval
    import flag_ctrl_pkg::*;
#(
    parameter int COND_W = 3
) (
    input  logic [COND_W-1:0] cond_i,
    input  logic [2:0]        flags_i,
    output logic              take_o
);

    always_comb begin
        take_o = 1'b0;
        // codes beyond the defined set (wide COND_W) never take
        case (cond_i)
            COND_W'(CC_ALWAYS): take_o = 1'b1;
            COND_W'(CC_C):      take_o = flags_i[FLAG_C];
            COND_W'(CC_NC):     take_o = ~flags_i[FLAG_C];
            COND_W'(CC_Z):      take_o = flags_i[FLAG_Z];
            COND_W'(CC_NZ):     take_o = ~flags_i[FLAG_Z];
            COND_W'(CC_B):      take_o = flags_i[FLAG_B];
            COND_W'(CC_NB):     take_o = ~flags_i[FLAG_B];
            default:            take_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_ctrl.sv
// Flag-register controller: ALU updates, CLR, and a two-state TST pipeline feeding an external flag register.
// Define FLAG_SHADOW_EN to add the one-entry SAVE/RESTORE shadow with sticky overflow.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | ops accepted; TST latches cond and moves to ST_EVAL
//   ST_EVAL | busy; evaluate latched cond on current flags, ops dropped
module flag_ctrl
    import flag_ctrl_pkg::*;
#(
    parameter int COND_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic              alu_c,
    input  logic              alu_z,
    input  logic              alu_b,
    input  logic [2:0]        upd_mask,
    input  logic [2:0]        op,
    input  logic [COND_W-1:0] cond,
    input  logic              flag_c,
    input  logic              flag_z,
    input  logic              flag_b,
    output logic              flag_c_in,
    output logic              flag_z_in,
    output logic              flag_b_in,
    output logic              flag_rst,
    output logic              busy,
    output logic              branch_valid,
    output logic              branch_take,
    output logic              shadow_ovf
);

    state_e              state_q, state_d;
    logic [COND_W-1:0]   cond_q, cond_d;
    logic                bv_q, bv_d;
    logic                bt_q, bt_d;
    logic [2:0]          flags_cur, flags_nxt, alu_bits;
    logic                accept, take, restore_hit;
    logic [2:0]          shadow_flags;

    assign flags_cur = {flag_c, flag_z, flag_b};
    assign alu_bits  = {alu_c, alu_z, alu_b};
    assign accept    = (state_q == ST_IDLE);

    flag_cond_eval #(.COND_W(COND_W)) u_cond_eval (
        .cond_i  (cond_q),
        .flags_i (flags_cur),
        .take_o  (take)
    );

`ifdef FLAG_SHADOW_EN
    logic [2:0] shadow_q, shadow_d;
    logic       sv_q, sv_d;
    logic       ovf_q, ovf_d;

    always_comb begin
        shadow_d = shadow_q;
        sv_d     = sv_q;
        ovf_d    = ovf_q;
        if (accept && (op == OP_SAVE)) begin
            shadow_d = flags_cur;
            sv_d     = 1'b1;
            ovf_d    = ovf_q | sv_q;
        end else if (accept && (op == OP_RESTORE) && sv_q) begin
            sv_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= 3'b000;
            sv_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            sv_q     <= sv_d;
            ovf_q    <= ovf_d;
        end
    end

    assign restore_hit  = accept && (op == OP_RESTORE) && sv_q;
    assign shadow_flags = shadow_q;
    assign shadow_ovf   = ovf_q;
`else
    assign restore_hit  = 1'b0;
    assign shadow_flags = 3'b000;
    assign shadow_ovf   = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cond_d    = cond_q;
        bv_d      = 1'b0;
        bt_d      = 1'b0;
        flag_rst  = rst;
        flags_nxt = flags_cur;

        case (state_q)
            ST_IDLE: begin
                if (op == OP_TST) begin
                    state_d = ST_EVAL;
                    cond_d  = cond;
                end
            end
            ST_EVAL: begin
                state_d = ST_IDLE;
                bv_d    = 1'b1;
                bt_d    = take;
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept && (op == OP_CLR))
            flag_rst = 1'b1;

        if (flag_rst) begin
            flags_nxt = 3'b000;
        end else if (restore_hit) begin
            flags_nxt = shadow_flags;
        end else if (alu_valid) begin
            for (int i = 0; i < 3; i++)
                if (upd_mask[i]) flags_nxt[i] = alu_bits[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cond_q  <= '0;
            bv_q    <= 1'b0;
            bt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cond_q  <= cond_d;
            bv_q    <= bv_d;
            bt_q    <= bt_d;
        end
    end

    assign flag_c_in    = flags_nxt[FLAG_C];
    assign flag_z_in    = flags_nxt[FLAG_Z];
    assign flag_b_in    = flags_nxt[FLAG_B];
    assign busy         = (state_q == ST_EVAL);
    assign branch_valid = bv_q;
    assign branch_take  = bt_q;

endmodule

// File: tb/tb_flag_ctrl.sv
// Testbench for flag_ctrl with a local flag register; directed scenarios then random traffic vs a cycle model.
// Expectations for SAVE/RESTORE follow whether FLAG_SHADOW_EN is defined.
module tb_flag_ctrl;

    logic       clk = 1'b0;
    logic       rst, alu_valid, alu_c, alu_z, alu_b;
    logic [2:0] upd_mask, op, cond;
    logic       flag_c, flag_z, flag_b;
    logic       flag_c_in, flag_z_in, flag_b_in, flag_rst;
    logic       busy, branch_valid, branch_take, shadow_ovf;

    int errors = 0;
    int checks = 0;

`ifdef FLAG_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    always #5 clk = ~clk;

    flag_ctrl #(.COND_W(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_valid    (alu_valid),
        .alu_c        (alu_c),
        .alu_z        (alu_z),
        .alu_b        (alu_b),
        .upd_mask     (upd_mask),
        .op           (op),
        .cond         (cond),
        .flag_c       (flag_c),
        .flag_z       (flag_z),
        .flag_b       (flag_b),
        .flag_c_in    (flag_c_in),
        .flag_z_in    (flag_z_in),
        .flag_b_in    (flag_b_in),
        .flag_rst     (flag_rst),
        .busy         (busy),
        .branch_valid (branch_valid),
        .branch_take  (branch_take),
        .shadow_ovf   (shadow_ovf)
    );

    // the flag register lives outside flag_ctrl
    always_ff @(posedge clk) begin
        if (flag_rst) begin
            flag_c <= 1'b0;
            flag_z <= 1'b0;
            flag_b <= 1'b0;
        end else begin
            flag_c <= flag_c_in;
            flag_z <= flag_z_in;
            flag_b <= flag_b_in;
        end
    end

    // reference model: m_f[2]=C, [1]=Z, [0]=B
    bit [2:0] m_f = 3'b000;
    bit       m_busy = 1'b0;
    bit [2:0] m_cond = 3'd0;
    bit       m_bv = 1'b0, m_bt = 1'b0;
    bit [2:0] m_sh = 3'b000;
    bit       m_sv = 1'b0, m_ovf = 1'b0;

    function automatic bit cond_true(input bit [2:0] c, input bit [2:0] f);
        case (c)
            3'd0: return 1'b1;
            3'd1: return f[2];
            3'd2: return !f[2];
            3'd3: return f[1];
            3'd4: return !f[1];
            3'd5: return f[0];
            3'd6: return !f[0];
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit av, input bit c, input bit z, input bit b,
                         input bit [2:0] mask, input bit [2:0] o, input bit [2:0] cc);
        rst = r; alu_valid = av; alu_c = c; alu_z = z; alu_b = b;
        upd_mask = mask; op = o; cond = cc;
    endtask

    task automatic model_step();
        bit       acc;
        bit [2:0] nf;
        if (rst) begin
            m_f = 3'b000; m_busy = 0; m_bv = 0; m_bt = 0; m_sv = 0; m_ovf = 0;
            return;
        end
        acc  = !m_busy;
        m_bv = m_busy;
        m_bt = m_busy && cond_true(m_cond, m_f);
        nf   = m_f;
        if (acc && op == 3'd1) begin
            nf = 3'b000;
        end else if (SHADOW && acc && op == 3'd4 && m_sv) begin
            nf = m_sh;
        end else if (alu_valid) begin
            if (upd_mask[2]) nf[2] = alu_c;
            if (upd_mask[1]) nf[1] = alu_z;
            if (upd_mask[0]) nf[0] = alu_b;
        end
        if (SHADOW && acc && op == 3'd3) begin
            m_ovf = m_ovf | m_sv;
            m_sh  = m_f;
            m_sv  = 1'b1;
        end else if (SHADOW && acc && op == 3'd4 && m_sv) begin
            m_sv = 1'b0;
        end
        if (acc && op == 3'd2) m_cond = cond;
        m_busy = acc && (op == 3'd2);
        m_f    = nf;
    endtask

    // one clock: combinational checks at negedge, registered checks #1 after posedge
    task automatic cycle();
        @(negedge clk);
        chk("flag_rst", flag_rst, rst || (!m_busy && op == 3'd1));
        if (!rst) begin
            chk("busy_pre", busy, m_busy);
            chk("ovf_pre", shadow_ovf, m_ovf);
        end
        model_step();
        @(posedge clk);
        #1;
        chk("flag_c", flag_c, m_f[2]);
        chk("flag_z", flag_z, m_f[1]);
        chk("flag_b", flag_b, m_f[0]);
        chk("busy", busy, m_busy);
        chk("branch_valid", branch_valid, m_bv);
        chk("branch_take", branch_take, m_bt);
        chk("shadow_ovf", shadow_ovf, m_ovf);
    endtask

    initial begin
        drive(1, 1, 1, 1, 1, 3'b111, 3'd0, 3'd0);
        @(posedge clk); #1;

        // reset with ALU inputs active
        cycle();
        cycle();
        chk("rst_flag_rst", flag_rst, 1'b1);
        chk("rst_c", flag_c, 1'b0);
        chk("rst_z", flag_z, 1'b0);
        chk("rst_b", flag_b, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_bv", branch_valid, 1'b0);

        // masked update
        drive(0, 1, 1, 1, 0, 3'b100, 3'd0, 3'd0);
        cycle();
        chk("mask_c", flag_c, 1'b1);
        chk("mask_z", flag_z, 1'b0);
        drive(0, 1, 0, 1, 1, 3'b000, 3'd0, 3'd0);
        repeat (5) cycle();
        chk("mask_hold_c", flag_c, 1'b1);

        // hazard: ALU sets Z in the same cycle as TST on Z
        drive(0, 1, 0, 1, 0, 3'b010, 3'd2, 3'd3);
        cycle();
        drive(0, 0, 0, 0, 0, 3'b000, 3'd1, 3'd0);
        #1;
        chk("haz_busy", busy, 1'b1);
        chk("haz_drop_clr", flag_rst, 1'b0);
        cycle();
        chk("haz_bv", branch_valid, 1'b1);
        chk("haz_bt", branch_take, 1'b1);
        chk("haz_z_kept", flag_z, 1'b1);
        drive(0, 0, 0, 0, 0, 3'b000, 3'd0, 3'd0);
        cycle();
        chk("haz_bv_once", branch_valid, 1'b0);

        // CLR beats ALU update
        drive(0, 1, 1, 1, 1, 3'b111, 3'd1, 3'd0);
        cycle();
        chk("clr_c", flag_c, 1'b0);
        chk("clr_z", flag_z, 1'b0);
        chk("clr_b", flag_b, 1'b0);

        // shadow SAVE / CLR / RESTORE
        drive(0, 1, 1, 0, 0, 3'b100, 3'd0, 3'd0); cycle();
        drive(0, 0, 0, 0, 0, 3'b000, 3'd3, 3'd0); cycle();
        drive(0, 0, 0, 0, 0, 3'b000, 3'd1, 3'd0); cycle();
        drive(0, 0, 0, 0, 0, 3'b000, 3'd4, 3'd0); cycle();
        chk("restore_c", flag_c, SHADOW);
        drive(0, 0, 0, 0, 0, 3'b000, 3'd3, 3'd0); cycle(); cycle();
        drive(0, 0, 0, 0, 0, 3'b000, 3'd0, 3'd0); repeat (3) cycle();
        chk("ovf_sticky", shadow_ovf, SHADOW);
        drive(1, 0, 0, 0, 0, 3'b000, 3'd0, 3'd0); cycle();
        chk("ovf_rst", shadow_ovf, 1'b0);

        // reset while evaluating
        drive(0, 0, 0, 0, 0, 3'b000, 3'd2, 3'd0); cycle();
        chk("mid_busy", busy, 1'b1);
        drive(1, 0, 0, 0, 0, 3'b000, 3'd0, 3'd0); cycle();
        chk("mid_busy_after", busy, 1'b0);
        chk("mid_no_bv", branch_valid, 1'b0);
        drive(0, 0, 0, 0, 0, 3'b000, 3'd0, 3'd0); cycle();
        chk("mid_no_bv2", branch_valid, 1'b0);

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(63) == 0), $urandom_range(1), $urandom_range(1),
                  $urandom_range(1), $urandom_range(1), 3'($urandom_range(7)),
                  3'($urandom_range(7)), 3'($urandom_range(7)));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/flag_ctrl.md
FLAG_CTRL -- requirements
Module: flag_ctrl

Interface
REQ-001 SHALL have parameter COND_W, default 3, width of the branch-condition select.
REQ-002 SHALL have ports, in order:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result present this cycle.
- alu_c / alu_z / alu_b  in  1 each  ALU carry / zero / borrow.
- upd_mask  in  3  per-flag update enable, [2]=C [1]=Z [0]=B.
- op  in  3  0 NOP, 1 CLR, 2 TST, 3 SAVE, 4 RESTORE, 5-7 NOP.
- cond  in  COND_W  TST condition select.
- flag_c / flag_z / flag_b  in  1 each  current flag register outputs.
- flag_c_in / flag_z_in / flag_b_in  out  1 each  next flag values to the flag register.
- flag_rst  out  1  flag register clear.
- busy  out  1  TST in progress; op not accepted.
- branch_valid  out  1  one-cycle TST result strobe.
- branch_take  out  1  TST result, qualified by branch_valid.
- shadow_ovf  out  1  sticky nested-SAVE error.

Function
REQ-003 The flag register latches flag_*_in every clk edge; flag_ctrl SHALL drive each flag_x_in = current flag_x unless that flag is being updated.
REQ-004 alu_valid=1 with upd_mask[i]=1 SHALL drive the matching alu_* onto flag_*_in; masked flags hold; the value is visible on flag_* in the next cycle.
REQ-005 alu_valid SHALL be honoured in every state, including while busy=1.
REQ-006 op=CLR accepted in cycle N SHALL assert flag_rst combinationally in cycle N only; flags read 0 in N+1.
REQ-007 FSM states SHALL be IDLE and EVAL; ops are accepted only in IDLE (busy=0); ops presented in EVAL are dropped.
REQ-008 TST accepted in N SHALL transition IDLE->EVAL and latch cond; busy=1 during N+1.
REQ-009 In EVAL (N+1) the condition SHALL be evaluated on flag_* as they stand in N+1, i.e. including any update from N but not from N+1.
REQ-010 branch_valid=1 with branch_take SHALL be registered and asserted in N+2 for exactly one cycle; the FSM returns EVAL->IDLE at the end of N+1.
REQ-011 Condition codes SHALL be: 0 ALWAYS, 1 C, 2 NC, 3 Z, 4 NZ, 5 B, 6 NB, 7 NEVER.
REQ-012 Same-cycle priority SHALL be: rst > CLR > RESTORE > ALU update > hold. A masked-off flag in an ALU update also holds under RESTORE rules (REQ-016).
REQ-013 Back-to-back TST is permitted: a new TST may be accepted in N+2, while branch_valid is high.

Reset
REQ-014 rst SHALL force state IDLE, busy=0, branch_valid=0, branch_take=0, shadow_ovf=0, shadow empty, and flag_rst=1 for that cycle, so flags read 0 after reset.

Configuration
REQ-015 Macro FLAG_SHADOW_EN SHALL compile in a one-entry shadow of C/Z/B with a valid bit.
REQ-016 With FLAG_SHADOW_EN defined:
- SAVE copies flag_* to the shadow and sets valid; SAVE while valid sets shadow_ovf and overwrites.
- RESTORE with valid drives the shadow onto flag_*_in and clears valid.
- RESTORE without valid behaves as NOP.
REQ-017 Without FLAG_SHADOW_EN, SAVE and RESTORE SHALL be NOPs and shadow_ovf SHALL be tied to 0.

Structure
REQ-018 A shared package SHALL hold the op encodings, condition encodings, FSM state enum and the flag-bit index constants (C=2, Z=1, B=0).
REQ-019 One sub-module, flag_cond_eval (combinational condition decoder), SHALL be instantiated. flag_reg itself is not instantiated inside flag_ctrl.

Verification
REQ-020 The bench SHALL instantiate flag_ctrl connected to flag_reg and cover these directed scenarios:
- Reset: rst=1 for 2 cycles with alu inputs at 1 -> flag_rst=1, all flags 0, busy=0, branch_valid=0.
- Masked update: alu_valid=1, alu_c=1, alu_z=1, upd_mask=3'b100 -> next cycle C=1, Z=0; mask 0 for 5 cycles -> C stays 1.
- Hazard: alu_valid with alu_z=1 and TST cond=3 in the same cycle N -> busy=1 in N+1, branch_valid=1 and branch_take=1 in N+2; an op in N+1 is dropped.
- CLR vs ALU: CLR and alu_valid with upd_mask=3'b111 and all alu_* =1 in the same cycle -> flags all 0 next cycle.
- Shadow (FLAG_SHADOW_EN): C=1, SAVE, CLR, RESTORE -> C=1 again; SAVE twice -> shadow_ovf=1 until rst; built without the macro -> RESTORE leaves flags at 0.
- Reset mid-TST: rst asserted in EVAL -> branch_valid never pulses and state is IDLE next cycle.
